// File: rtl/cs_uart_vga_ctrl.sv
// UART command receiver + VGA 640x480 timing; `define VGA_TEST_PATTERN_EN adds colour bars.
// Video outputs 1 clk after counters; no backpressure, each valid byte is applied the cycle after its stop bit.
module cs_uart_vga_ctrl #(
  parameter int CLKS_PER_BIT_9600 = 46880,
  parameter int PIX_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in,
  input  logic        btnHS,
  input  logic        btnVS,
  input  logic        btnUART,
  input  logic        btnVGA,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic [15:0] LEDS,
  output logic [3:0]  RED,
  output logic [3:0]  GREEN,
  output logic [3:0]  BLUE
);

  localparam int BW = $clog2(CLKS_PER_BIT_9600 * 2 + 1);
  localparam int PW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [9:0] H_ACT_L = 10'(H_ACTIVE);
  localparam logic [9:0] H_SS    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT_L = 10'(V_ACTIVE);
  localparam logic [9:0] V_SS    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} rx_state_t;

  logic            r_rx_meta, r_rx;
  rx_state_t       r_state;
  logic [BW-1:0]   r_cnt, r_bit_clks, w_bit_clks, w_half;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift, r_last;
  logic            r_par, r_byte_vld, r_par_err, r_frm_err, r_cfg_err;
  logic [1:0]      r_baud_sel;
  logic [3:0]      r_red, r_green, r_blue;
  logic            w_pat_en;
  logic [PW-1:0]   r_pix_cnt;
  logic [9:0]      r_h, r_v;
  logic            w_pix_tick, w_active, w_hs_low, w_vs_low;
  logic [11:0]     w_rgb;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx      <= 1'b1;
    end else begin
      r_rx_meta <= in;
      r_rx      <= r_rx_meta;
    end
  end

  always_comb begin
    case (r_baud_sel)
      2'b01:   w_bit_clks = BW'(CLKS_PER_BIT_9600 * 2);
      2'b10:   w_bit_clks = BW'(CLKS_PER_BIT_9600 / 2);
      default: w_bit_clks = BW'(CLKS_PER_BIT_9600);
    endcase
  end
  assign w_half = r_bit_clks >> 1;

  // Bit period is latched at the start edge so a rate change never splits a frame.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_clks <= BW'(CLKS_PER_BIT_9600);
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_last     <= '0;
      r_byte_vld <= 1'b0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
    end else begin
      r_byte_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_rx) begin
            r_state    <= S_START;
            r_cnt      <= '0;
            r_bit_clks <= w_bit_clks;
          end
        end
        S_START: begin
          if (r_cnt == w_half - BW'(1)) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= r_rx ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + BW'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == r_bit_clks - BW'(1)) begin
            r_cnt     <= '0;
            r_shift   <= {r_rx, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_state <= S_PARITY;
          end else begin
            r_cnt <= r_cnt + BW'(1);
          end
        end
        S_PARITY: begin
          if (r_cnt == r_bit_clks - BW'(1)) begin
            r_cnt   <= '0;
            r_par   <= r_rx;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + BW'(1);
          end
        end
        S_STOP: begin
          if (r_cnt == r_bit_clks - BW'(1)) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            if (!r_rx) r_frm_err <= 1'b1;
            if (!(^{r_shift, r_par})) r_par_err <= 1'b1;
            if (r_rx && (^{r_shift, r_par})) begin
              r_byte_vld <= 1'b1;
              r_last     <= r_shift;
            end
          end else begin
            r_cnt <= r_cnt + BW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_baud_sel <= 2'b00;
      r_cfg_err  <= 1'b0;
      r_red      <= '0;
      r_green    <= '0;
      r_blue     <= '0;
    end else if (r_byte_vld) begin
      case (r_last[7:6])
        2'b10: begin
          if (r_last[1:0] == 2'b11) r_cfg_err  <= 1'b1;
          else                      r_baud_sel <= r_last[1:0];
        end
        2'b01: begin
          case (r_last[5:4])
            2'b00:   r_red   <= r_last[3:0];
            2'b01:   r_green <= r_last[3:0];
            2'b10:   r_blue  <= r_last[3:0];
            default: r_cfg_err <= 1'b1;
          endcase
        end
`ifdef VGA_TEST_PATTERN_EN
        2'b11:   ;
`endif
        default: r_cfg_err <= 1'b1;
      endcase
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic       r_pat_en;
  logic [9:0] w_bar;
  always_ff @(posedge clk) begin
    if (rst_n)                                   r_pat_en <= 1'b0;
    else if (r_byte_vld && r_last[7:6] == 2'b11) r_pat_en <= r_last[0];
  end
  assign w_pat_en = r_pat_en;
  assign w_bar    = r_h / 10'd80;
  assign w_rgb    = r_pat_en ? {{4{w_bar[2]}}, {4{w_bar[1]}}, {4{w_bar[0]}}}
                             : {r_red, r_green, r_blue};
`else
  assign w_pat_en = 1'b0;
  assign w_rgb    = {r_red, r_green, r_blue};
`endif

  assign w_pix_tick = (r_pix_cnt == PW'(PIX_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_pix_cnt <= '0;
      r_h       <= '0;
      r_v       <= '0;
    end else if (w_pix_tick) begin
      r_pix_cnt <= '0;
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
      end else begin
        r_h <= r_h + 10'd1;
      end
    end else begin
      r_pix_cnt <= r_pix_cnt + PW'(1);
    end
  end

  assign w_active = (r_h < H_ACT_L) && (r_v < V_ACT_L);
  assign w_hs_low = (r_h >= H_SS) && (r_h < H_SE);
  assign w_vs_low = (r_v >= V_SS) && (r_v < V_SE);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      HSYNC <= ~btnHS;
      VSYNC <= ~btnVS;
      {RED, GREEN, BLUE} <= '0;
    end else begin
      HSYNC <= ~w_hs_low ^ btnHS;
      VSYNC <= ~w_vs_low ^ btnVS;
      {RED, GREEN, BLUE} <= (w_active && btnVGA) ? w_rgb : 12'h000;
    end
  end

  assign LEDS = btnUART ? {2'b00, w_pat_en, r_baud_sel, r_cfg_err, r_frm_err, r_par_err, r_last}
                        : {r_red, r_green, r_blue, r_baud_sel, r_par_err | r_frm_err, r_cfg_err};

endmodule

// File: tb/tb_cs_uart_vga_ctrl.sv
// Directed bench for cs_uart_vga_ctrl: UART command vectors from a table, then VGA timing,
// sync inversion, video enable and mid-frame reset sequences.
module tb_cs_uart_vga_ctrl;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rx = 1'b1;
  logic        btnHS = 1'b0, btnVS = 1'b0, btnUART = 1'b0, btnVGA = 1'b0;
  logic        HSYNC, VSYNC;
  logic [15:0] LEDS;
  logic [3:0]  RED, GREEN, BLUE;

  cs_uart_vga_ctrl #(
    .CLKS_PER_BIT_9600(CPB), .PIX_DIV(4),
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in(rx),
    .btnHS(btnHS), .btnVS(btnVS), .btnUART(btnUART), .btnVGA(btnVGA),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .LEDS(LEDS),
    .RED(RED), .GREEN(GREEN), .BLUE(BLUE)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  logic        cnt_en = 1'b0;
  logic [11:0] exp_rgb = 12'h000;
  int          n_match = 0;
  int          n_bad = 0;
  always @(negedge clk) begin
    if (cnt_en) begin
      if ({RED, GREEN, BLUE} == exp_rgb)       n_match++;
      else if ({RED, GREEN, BLUE} != 12'h000) n_bad++;
    end
  end

  typedef struct {
    logic [7:0]  dat;
    bit          par_flip;
    bit          stop;
    int          cpb;
    logic [15:0] exp_uart;
    logic [15:0] exp_stat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pf, input bit sb, input int cpb);
    logic [10:0] bits;
    bits = {sb, (~^d) ^ pf, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx = bits[i];
      repeat (cpb) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic check_leds(input string nm, input logic [15:0] e_uart, input logic [15:0] e_stat);
    btnUART = 1'b1;
    #1 chk({nm, " uart view"}, 32'(LEDS), 32'(e_uart));
    btnUART = 1'b0;
    #1 chk({nm, " status view"}, 32'(LEDS), 32'(e_stat));
  endtask

  function automatic logic sig(input bit use_v);
    return use_v ? VSYNC : HSYNC;
  endfunction

  // Returns the cycle at which the chosen sync reaches val after having left it; -1 on timeout.
  task automatic wait_edge(input bit use_v, input logic val, input int budget, output int t);
    int n;
    n = 0;
    t = -1;
    while (sig(use_v) === val && n < budget) begin @(negedge clk); n++; end
    while (sig(use_v) !== val && n < budget) begin @(negedge clk); n++; end
    if (n < budget) t = cyc;
  endtask

  initial begin
    int t0, t1, t2;

    vecs[0]  = '{8'h81, 0, 1, CPB,     16'h0881, 16'h0004};
    vecs[1]  = '{8'h4A, 0, 1, CPB * 2, 16'h084A, 16'hA004};
    vecs[2]  = '{8'h51, 1, 1, CPB * 2, 16'h094A, 16'hA006};
    vecs[3]  = '{8'h00, 0, 1, CPB * 2, 16'h0D00, 16'hA007};
    vecs[4]  = '{8'h83, 0, 1, CPB * 2, 16'h0D83, 16'hA007};
    vecs[5]  = '{8'h80, 0, 1, CPB * 2, 16'h0580, 16'hA003};
    vecs[6]  = '{8'h5F, 0, 1, CPB,     16'h055F, 16'hAF03};
    vecs[7]  = '{8'h4A, 0, 0, CPB,     16'h075F, 16'hAF03};
    vecs[8]  = '{8'h82, 0, 1, CPB,     16'h1782, 16'hAF0B};
    vecs[9]  = '{8'h6C, 0, 1, CPB / 2, 16'h176C, 16'hAFCB};
    vecs[10] = '{8'h73, 0, 1, CPB / 2, 16'h1773, 16'hAFCB};
`ifdef VGA_TEST_PATTERN_EN
    vecs[11] = '{8'hC1, 0, 1, CPB / 2, 16'h37C1, 16'hAFCB};
`else
    vecs[11] = '{8'hC1, 0, 1, CPB / 2, 16'h17C1, 16'hAFCB};
`endif
    vecs[12] = '{8'hC0, 0, 1, CPB / 2, 16'h17C0, 16'hAFCB};

    repeat (500) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset rgb", 32'({RED, GREEN, BLUE}), 32'h0);
    chk("reset hsync", 32'(HSYNC), 32'h1);
    chk("reset vsync", 32'(VSYNC), 32'h1);
    check_leds("reset leds", 16'h0000, 16'h0000);
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      send_frame(vecs[i].dat, vecs[i].par_flip, vecs[i].stop, vecs[i].cpb);
      repeat (vecs[i].cpb + 4) @(negedge clk);
      check_leds($sformatf("vec%0d byte %02h", i, vecs[i].dat), vecs[i].exp_uart, vecs[i].exp_stat);
      @(negedge clk);
    end

    btnVGA = 1'b1;
    wait_edge(0, 1'b0, 8000, t0);
    wait_edge(0, 1'b1, 8000, t1);
    wait_edge(0, 1'b0, 8000, t2);
    chk("hsync low width", 32'(t1 - t0), 32'd384);
    chk("hsync period", 32'(t2 - t0), 32'd3200);

    wait_edge(1, 1'b0, 40000, t0);
    exp_rgb = 12'hAFC; n_match = 0; n_bad = 0; cnt_en = 1'b1;
    wait_edge(1, 1'b1, 40000, t1);
    wait_edge(1, 1'b0, 40000, t2);
    cnt_en = 1'b0;
    chk("vsync low width", 32'(t1 - t0), 32'd6400);
    chk("vsync period", 32'(t2 - t0), 32'd19200);
    chk("active colour cycles", 32'(n_match), 32'd5120);
    chk("stray colour cycles", 32'(n_bad), 32'd0);

    btnHS = 1'b1; btnVS = 1'b1;
    repeat (2) @(negedge clk);
    chk("vsync inverted in sync line", 32'(VSYNC), 32'h1);
    wait_edge(0, 1'b1, 8000, t0);
    wait_edge(0, 1'b0, 8000, t1);
    chk("inverted hsync high width", 32'(t1 - t0), 32'd384);

    btnVGA = 1'b0; btnHS = 1'b0; btnVS = 1'b0;
    @(negedge clk);
    exp_rgb = 12'h000; n_match = 0; n_bad = 0; cnt_en = 1'b1;
    repeat (19200) @(negedge clk);
    cnt_en = 1'b0;
    chk("video disabled nonzero rgb", 32'(n_bad), 32'd0);

    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    btnHS = 1'b1; btnVS = 1'b1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midframe reset hsync", 32'(HSYNC), 32'h0);
    chk("midframe reset vsync", 32'(VSYNC), 32'h0);
    chk("midframe reset rgb", 32'({RED, GREEN, BLUE}), 32'h0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    btnHS = 1'b0; btnVS = 1'b0;
    repeat (2) @(negedge clk);
    check_leds("after midframe reset", 16'h0000, 16'h0000);
    @(negedge clk);

    send_frame(8'h4A, 0, 1, CPB);
    repeat (CPB + 4) @(negedge clk);
    check_leds("9600 after reset", 16'h004A, 16'hA000);
    @(negedge clk);

    send_frame(8'h5F, 0, 1, CPB);
    send_frame(8'h6C, 0, 1, CPB);
    repeat (CPB + 4) @(negedge clk);
    check_leds("back-to-back frames", 16'h006C, 16'hAFC0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
